hamming_serial_tx: RTL and testbench
====================================

// Module: hamming_serial_tx
// PURPOSE
//  Transmit end of the 8-bit Hamming SEC link: takes a data byte on a valid/ready handshake, builds the 12-bit codeword and shifts it out serially.
//  Codeword is position-indexed [1:12]; the parity-checking receiver consumes exactly this layout.
//  Parity at 1,2,4,8 (even parity); data D7..D0 (MSB first) at 3,5,6,7,9,10,11,12.
// PARAMETERS
//  GAP_CYCLES  1  idle cycles forced after each frame (0 = back-to-back frames allowed)
//  IDLE_LEVEL  0  ser_out level when no frame is active
// PORTS
//  clk        in   1        single clock, all logic on rising edge
//  rst        in   1        synchronous, active-high reset
//  data_in    in   8        byte to send; data_in[7] goes to position 3
//  data_valid in   1        data_in is valid this cycle
//  data_ready out  1        block can accept a byte this cycle
//  code_out   out  [1:CW]   registered codeword of current/last frame (CW=12, or 13 with SECDED)
//  ser_out    out  1        serial line, position 1 first
//  ser_valid  out  1        high while a codeword bit is on ser_out
//  ser_first  out  1        high with position-1 bit only
//  frame_done out  1        1-cycle pulse in the cycle after the last bit
// BEHAVIOUR
//  Reset: data_ready=0 during rst, 1 in the cycle after; code_out=0, ser_out=IDLE_LEVEL, ser_valid=ser_first=frame_done=0; FSM->IDLE, bit counter=0.
//  Reset mid-frame aborts immediately; no partial-frame completion and no frame_done.
//  Parity: p1=^{3,5,7,9,11}; p2=^{3,6,7,10,11}; p4=^{5,6,7,12}; p8=^{9,10,11,12}.
//  FSM IDLE: data_ready=1; accept on data_valid&&data_ready at edge E -> code_out latched, go SHIFT.
//  SHIFT: cycle after E shows position 1 (ser_first=1); position k on cycle E+k; ser_valid=1 throughout.
//   data_ready=0 in SHIFT, except on last bit when GAP_CYCLES==0 (accept there -> next frame's position 1 directly follows, no idle cycle).
//  After last bit: frame_done=1 for one cycle; go GAP if GAP_CYCLES>0, else IDLE (or SHIFT if back-to-back accept).
//  GAP: ser_out=IDLE_LEVEL, data_ready=0, count GAP_CYCLES cycles, then IDLE.
//  data_in/data_valid ignored while data_ready=0; accepted byte is held internally, not re-sampled.
//  Latency: acceptance edge to first bit = 1 cycle; frame length CW cycles.
//  Bit counter 4 bits, counts 1..CW, never wraps beyond CW; gap counter width $clog2(GAP_CYCLES+1).
// CONFIGURATION
//  HAMMING_SECDED_EN defined: CW=13, position 13 = ^code[1:12] (overall even parity) sent after position 12.
//  Not defined: CW=12, frames end at position 12; no overall parity logic present.
// STRUCTURE
//  hamming_pkg: CW constant (macro-dependent), parity position/coverage constants, FSM state typedef {IDLE,SHIFT,GAP}.
//  Sub-module hamming_enc8: combinational 8-bit -> [1:CW] encoder, shared with future loopback benches.
//  Top holds FSM, bit/gap counters, codeword shift register.
// TESTING
//  data 8'h04 -> code_out 010000010100; serial 0,1,0,0,0,0,0,1,0,1,0,0 on cycles E+1..E+12.
//  data 8'hFF -> 111011101111; SECDED build appends 0; data 8'h00 -> all zeros, SECDED bit 0.
//  SECDED build, data 8'h04 -> position 13 = 1; frame_done at E+14.
//  GAP_CYCLES=0, data_valid held high with 8'h09 then 8'hFF -> 100100001001 then 111011101111 with no idle cycle between, ser_valid continuous.
//  GAP_CYCLES=2: data_ready stays 0 for 2 cycles after frame_done cycle; data_valid asserted then is ignored.
//  rst asserted at E+5 -> next cycle ser_valid=0, ser_out=IDLE_LEVEL, no frame_done; following frame transmits correctly.
//  Loopback: every byte 0..255 encoded, passed through receiver with each single-bit flip -> original byte recovered.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared constants for the 8-bit Hamming SEC serial link.
// HAMMING_SECDED_EN adds an overall-parity bit at position 13 (CW=13).
package hamming_pkg;

`ifdef HAMMING_SECDED_EN
    localparam int CW = 13;
`else
    localparam int CW = 12;
`endif

    localparam logic [3:0] CW_LAST = 4'(CW);

    // Coverage masks over positions 1..12, position 1 is the leftmost bit.
    localparam logic [1:12] P1_MASK = 12'b001010101010;
    localparam logic [1:12] P2_MASK = 12'b001001100110;
    localparam logic [1:12] P4_MASK = 12'b000011100001;
    localparam logic [1:12] P8_MASK = 12'b000000001111;

    typedef logic [1:0] state_t;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

endpackage

// File: rtl/hamming_serial_tx_if.sv
// Byte handshake and serial line of the Hamming transmitter.
// Codeword width follows HAMMING_SECDED_EN through hamming_pkg::CW.
interface hamming_serial_tx_if;
    import hamming_pkg::*;

    // A byte transfers on a rising edge where data_valid && data_ready; data_in
    // and data_valid are don't-care whenever data_ready is low.
    logic [7:0]  data_in;
    logic        data_valid;
    logic        data_ready;
    logic [1:CW] code_out;
    logic        ser_out;
    logic        ser_valid;
    logic        ser_first;
    logic        frame_done;

    modport master (
        output data_in, data_valid,
        input  data_ready, code_out, ser_out, ser_valid, ser_first, frame_done
    );

    modport slave (
        input  data_in, data_valid,
        output data_ready, code_out, ser_out, ser_valid, ser_first, frame_done
    );

endinterface

// File: rtl/hamming_enc8.sv
// Combinational 8-bit to position-indexed [1:CW] Hamming encoder.
// With HAMMING_SECDED_EN the overall even parity is appended at position 13.
module hamming_enc8
    import hamming_pkg::*;
(
    input  logic [7:0]  data,
    output logic [1:CW] code
);

    logic [1:12] base;
    logic [1:12] word;

    always_comb begin
        base     = '0;
        base[3]  = data[7];
        base[5]  = data[6];
        base[6]  = data[5];
        base[7]  = data[4];
        base[9]  = data[3];
        base[10] = data[2];
        base[11] = data[1];
        base[12] = data[0];
        word     = base;
        word[1]  = ^(base & P1_MASK);
        word[2]  = ^(base & P2_MASK);
        word[4]  = ^(base & P4_MASK);
        word[8]  = ^(base & P8_MASK);
    end

`ifdef HAMMING_SECDED_EN
    assign code = {word, ^word};
`else
    assign code = word;
`endif

endmodule

// File: rtl/hamming_serial_tx.sv
// Hamming SEC transmitter: accepts a byte, latches its codeword, shifts it out position 1 first.
// HAMMING_SECDED_EN selects the 13-bit SECDED codeword.
module hamming_serial_tx
    import hamming_pkg::*;
#(
    parameter int   GAP_CYCLES = 1,
    parameter logic IDLE_LEVEL = 1'b0
)
(
    input  logic                clk,
    input  logic                rst,
    hamming_serial_tx_if.slave  link,
    output state_t              fsm_state
);

    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES);

    state_t        state;
    logic [3:0]    bit_cnt;
    logic [GW-1:0] gap_cnt;
    logic [1:CW]   shreg;
    logic [1:CW]   enc_code;
    logic          last_bit;
    logic          accept;

    hamming_enc8 u_enc (
        .data (link.data_in),
        .code (enc_code)
    );

    assign last_bit = (state == ST_SHIFT) && (bit_cnt == CW_LAST);
    assign accept   = link.data_valid && link.data_ready;

    // Back-to-back frames are only possible when no gap is configured.
    always_comb begin
        link.data_ready = 1'b0;
        if (!rst) begin
            if (state == ST_IDLE)
                link.data_ready = 1'b1;
            else if ((GAP_CYCLES == 0) && last_bit)
                link.data_ready = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            bit_cnt         <= 4'd0;
            gap_cnt         <= '0;
            shreg           <= '0;
            link.code_out   <= '0;
            link.frame_done <= 1'b0;
        end else begin
            link.frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        link.code_out <= enc_code;
                        shreg         <= enc_code;
                        bit_cnt       <= 4'd1;
                        state         <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (last_bit) begin
                        link.frame_done <= 1'b1;
                        if (accept) begin
                            link.code_out <= enc_code;
                            shreg         <= enc_code;
                            bit_cnt       <= 4'd1;
                        end else if (GAP_CYCLES > 0) begin
                            bit_cnt <= 4'd0;
                            gap_cnt <= GW'(1);
                            state   <= ST_GAP;
                        end else begin
                            bit_cnt <= 4'd0;
                            state   <= ST_IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                        shreg   <= {shreg[2:CW], 1'b0};
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST)
                        state <= ST_IDLE;
                    else
                        gap_cnt <= gap_cnt + GW'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign link.ser_valid = (state == ST_SHIFT);
    assign link.ser_first = (state == ST_SHIFT) && (bit_cnt == 4'd1);
    assign link.ser_out   = (state == ST_SHIFT) ? shreg[1] : IDLE_LEVEL;
    assign fsm_state      = state;

endmodule

// File: tb/tb_hamming_serial_tx.sv
// Bench for hamming_serial_tx: default, back-to-back (GAP=0) and GAP=2/IDLE_LEVEL=1 instances.
// Expected codewords follow HAMMING_SECDED_EN like the design.
module tb_hamming_serial_tx;
    import hamming_pkg::*;

`ifdef HAMMING_SECDED_EN
    localparam logic [1:CW] EXP_04 = {12'b010000010100, 1'b1};
    localparam logic [1:CW] EXP_FF = {12'b111011101111, 1'b0};
    localparam logic [1:CW] EXP_00 = {12'b000000000000, 1'b0};
    localparam logic [1:CW] EXP_09 = {12'b100100001001, 1'b0};
`else
    localparam logic [1:CW] EXP_04 = 12'b010000010100;
    localparam logic [1:CW] EXP_FF = 12'b111011101111;
    localparam logic [1:CW] EXP_00 = 12'b000000000000;
    localparam logic [1:CW] EXP_09 = 12'b100100001001;
`endif

    logic clk;
    logic rst;
    state_t st0, st1, st2;

    hamming_serial_tx_if bus0 ();
    hamming_serial_tx_if bus1 ();
    hamming_serial_tx_if bus2 ();

    hamming_serial_tx #(.GAP_CYCLES(1), .IDLE_LEVEL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .link(bus0), .fsm_state(st0));
    hamming_serial_tx #(.GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) dut1 (
        .clk(clk), .rst(rst), .link(bus1), .fsm_state(st1));
    hamming_serial_tx #(.GAP_CYCLES(2), .IDLE_LEVEL(1'b1)) dut2 (
        .clk(clk), .rst(rst), .link(bus2), .fsm_state(st2));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [1:CW] exp_q0[$];
    logic [1:CW] exp_q1[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference encoder: parity p covers every position whose index has bit p set.
    function automatic logic [1:CW] model_enc(input logic [7:0] d);
        logic [1:CW] c;
        int dp;
        logic par;
        c  = '0;
        dp = 7;
        for (int pos = 1; pos <= 12; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos] = d[dp];
                dp--;
            end
        end
        for (int p = 1; p <= 8; p = p * 2) begin
            par = 1'b0;
            for (int pos = 1; pos <= 12; pos++)
                if (((pos & p) != 0) && (pos != p)) par = par ^ c[pos];
            c[p] = par;
        end
        if (CW == 13) c[CW] = ^c[1:12];
        return c;
    endfunction

    // scoreboard monitors: rebuild each serial frame and pop its expectation
    int n0 = 0;
    int n1 = 0;
    logic [1:CW] rx0, rx1, e0, e1;

    always @(negedge clk) begin
        if (rst) n0 = 0;
        else if (bus0.ser_valid) begin
            if (bus0.ser_first) n0 = 0;
            n0++;
            rx0[n0] = bus0.ser_out;
            if (n0 == CW) begin
                n0 = 0;
                if (exp_q0.size() == 0) check("ser0_extra_frame", 32'(exp_q0.size()), 32'd1);
                else begin
                    e0 = exp_q0.pop_front();
                    check("ser0_word", 32'(rx0), 32'(e0));
                    check("code0_out", 32'(bus0.code_out), 32'(e0));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) n1 = 0;
        else if (bus1.ser_valid) begin
            if (bus1.ser_first) n1 = 0;
            n1++;
            rx1[n1] = bus1.ser_out;
            if (n1 == CW) begin
                n1 = 0;
                if (exp_q1.size() == 0) check("ser1_extra_frame", 32'(exp_q1.size()), 32'd1);
                else begin
                    e1 = exp_q1.pop_front();
                    check("ser1_word", 32'(rx1), 32'(e1));
                    check("code1_out", 32'(bus1.code_out), 32'(e1));
                end
            end
        end
    end

    // driver: offer a byte to dut0 until accepted; returns at the negedge of cycle E+1
    task automatic send0(input logic [7:0] d, input logic [1:CW] e, input bit push);
        int t;
        t = 0;
        bus0.data_in    = d;
        bus0.data_valid = 1'b1;
        while (!bus0.data_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("send0_ready_timeout", 32'(t < 200), 32'd1);
        if (push) exp_q0.push_back(e);
        @(negedge clk);
        bus0.data_valid = 1'b0;
        bus0.data_in    = 8'($urandom_range(0, 255));
    endtask

    logic [1:CW] e2a, e2b;
    logic [7:0]  rb;
    int t;

    initial begin
        rst = 1'b1;
        bus0.data_in = 8'h00; bus0.data_valid = 1'b0;
        bus1.data_in = 8'h00; bus1.data_valid = 1'b0;
        bus2.data_in = 8'h00; bus2.data_valid = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus0.data_ready), 32'd0);
        check("rst_code", 32'(bus0.code_out), 32'd0);
        check("rst_ser_out", 32'(bus0.ser_out), 32'd0);
        check("rst_ser_valid", 32'(bus0.ser_valid), 32'd0);
        check("rst_ser_first", 32'(bus0.ser_first), 32'd0);
        check("rst_frame_done", 32'(bus0.frame_done), 32'd0);
        check("rst_state", 32'(st0), 32'd0);
        check("rst_idle_level2", 32'(bus2.ser_out), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(bus0.data_ready), 32'd1);

        // byte 0x04: timing of first bit, frame_done and gap
        send0(8'h04, EXP_04, 1'b1);
        check("e1_ser_first", 32'(bus0.ser_first), 32'd1);
        check("e1_ready", 32'(bus0.data_ready), 32'd0);
        @(negedge clk);
        check("e2_ser_first", 32'(bus0.ser_first), 32'd0);
        repeat (CW - 1) @(negedge clk);
        check("done_pulse", 32'(bus0.frame_done), 32'd1);
        check("done_ser_valid", 32'(bus0.ser_valid), 32'd0);
        check("gap_ready", 32'(bus0.data_ready), 32'd0);
        @(negedge clk);
        check("done_single", 32'(bus0.frame_done), 32'd0);
        check("gap_end_ready", 32'(bus0.data_ready), 32'd1);

        // 0xFF with noise offered mid-frame, then 0x00
        send0(8'hFF, EXP_FF, 1'b1);
        bus0.data_in    = 8'hAA;
        bus0.data_valid = 1'b1;
        repeat (4) @(negedge clk);
        bus0.data_valid = 1'b0;
        send0(8'h00, EXP_00, 1'b1);

        // random bytes against the reference encoder
        for (int i = 0; i < 6; i++) begin
            rb = 8'($urandom_range(0, 255));
            send0(rb, model_enc(rb), 1'b1);
        end

        // reset mid-frame
        send0(8'h5A, model_enc(8'h5A), 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ser_valid", 32'(bus0.ser_valid), 32'd0);
        check("abort_ser_out", 32'(bus0.ser_out), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < CW; k++) begin
            @(negedge clk);
            check("abort_no_done", 32'(bus0.frame_done), 32'd0);
        end
        send0(8'h04, EXP_04, 1'b1);

        // back-to-back on the GAP_CYCLES=0 instance
        bus1.data_in    = 8'h09;
        bus1.data_valid = 1'b1;
        t = 0;
        while (!bus1.data_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("b2b_ready_timeout", 32'(t < 200), 32'd1);
        exp_q1.push_back(EXP_09);
        @(negedge clk);
        bus1.data_in = 8'hFF;
        for (int k = 1; k <= CW; k++) begin
            check("b2b_ser_valid", 32'(bus1.ser_valid), 32'd1);
            check("b2b_ready", 32'(bus1.data_ready), 32'(k == CW));
            if (k == CW) exp_q1.push_back(EXP_FF);
            @(negedge clk);
        end
        check("b2b_ser_first", 32'(bus1.ser_first), 32'd1);
        check("b2b_done", 32'(bus1.frame_done), 32'd1);
        bus1.data_valid = 1'b0;
        repeat (CW) @(negedge clk);
        check("b2b_done2", 32'(bus1.frame_done), 32'd1);
        check("b2b_idle_ready", 32'(bus1.data_ready), 32'd1);

        // GAP_CYCLES=2, IDLE_LEVEL=1: valid held through the gap is ignored
        e2a = model_enc(8'h3C);
        e2b = model_enc(8'h55);
        bus2.data_in    = 8'h3C;
        bus2.data_valid = 1'b1;
        @(negedge clk);
        bus2.data_in = 8'h55;
        check("g2_code", 32'(bus2.code_out), 32'(e2a));
        check("g2_first_bit", 32'(bus2.ser_out), 32'(e2a[1]));
        check("g2_ser_first", 32'(bus2.ser_first), 32'd1);
        repeat (CW) @(negedge clk);
        check("g2_done", 32'(bus2.frame_done), 32'd1);
        check("g2_ready_f0", 32'(bus2.data_ready), 32'd0);
        check("g2_idle_level", 32'(bus2.ser_out), 32'd1);
        @(negedge clk);
        check("g2_ready_f1", 32'(bus2.data_ready), 32'd0);
        check("g2_code_held", 32'(bus2.code_out), 32'(e2a));
        check("g2_gap_ser_valid", 32'(bus2.ser_valid), 32'd0);
        @(negedge clk);
        check("g2_ready_f2", 32'(bus2.data_ready), 32'd1);
        @(negedge clk);
        bus2.data_valid = 1'b0;
        check("g2_next_first", 32'(bus2.ser_first), 32'd1);
        check("g2_next_code", 32'(bus2.code_out), 32'(e2b));
        repeat (CW + 3) @(negedge clk);

        // drain scoreboards
        t = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("q0_empty", 32'(exp_q0.size()), 32'd0);
        check("q1_empty", 32'(exp_q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
